// File: rtl/resp_mux_n.sv
// resp_mux_n: N-slave response return path.
// Latches the target slave index at request time, accepts the response only
// from that slave, and registers it toward the master until accepted.
// Unmapped indices return DECERR; a silent slave returns TOERR after TIMEOUT
// cycles of waiting.
//
// Handshake semantics (both sides): a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge. Slave side: s_ready is
// raised only for the latched slave while waiting. s_valid is sampled only in
// that case. Master side: once m_valid rises, m_valid, m_resp and m_rdata stay
// constant until the cycle in which m_ready is 1.
module resp_mux_n #(
    parameter int NUM_SLAVES = 3,
    parameter int SEL_W      = 2,
    parameter int RESP_W     = 2,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         req_valid,
    input  logic [SEL_W-1:0]             req_sel,
    input  logic [NUM_SLAVES-1:0]        s_valid,
    input  logic [NUM_SLAVES*RESP_W-1:0] s_resp,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic [NUM_SLAVES-1:0]        s_ready,
    output logic                         m_valid,
    output logic [RESP_W-1:0]            m_resp,
    output logic [DATA_W-1:0]            m_rdata,
    input  logic                         m_ready,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    localparam logic [RESP_W-1:0] RESP_TOERR  = RESP_W'(2'b10);
    localparam logic [RESP_W-1:0] RESP_DECERR = RESP_W'(2'b11);
    localparam logic [SEL_W:0]    NUM_SLV     = (SEL_W + 1)'(NUM_SLAVES);
    localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                m_valid_q, m_valid_d;
    logic [RESP_W-1:0]   m_resp_q, m_resp_d;
    logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
    logic                timeout_err_q, timeout_err_d;

    logic                sel_valid;
    logic [RESP_W-1:0]   sel_resp;
    logic [DATA_W-1:0]   sel_rdata;

    // Pick the latched slave's channel; all other slaves are invisible.
    always_comb begin
        sel_valid = 1'b0;
        sel_resp  = '0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_valid = s_valid[i];
                sel_resp  = s_resp[i*RESP_W +: RESP_W];
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready goes only to the latched slave, and only while waiting for it.
    always_comb begin
        s_ready = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_ready[i] = (state_q == ST_WAIT) && (sel_q == SEL_W'(i));
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        timer_d       = timer_q;
        m_valid_d     = m_valid_q;
        m_resp_d      = m_resp_q;
        m_rdata_d     = m_rdata_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                m_valid_d = 1'b0;
                if (req_valid) begin
                    sel_d = req_sel;
                    if ({1'b0, req_sel} >= NUM_SLV) begin
                        m_resp_d  = RESP_DECERR;
                        m_rdata_d = '0;
                        m_valid_d = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        timer_d = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A response arriving on the last allowed cycle still wins.
                if (sel_valid) begin
                    m_resp_d  = sel_resp;
                    m_rdata_d = sel_rdata;
                    m_valid_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (timer_q == TMR_LAST) begin
                    m_resp_d      = RESP_TOERR;
                    m_rdata_d     = '0;
                    m_valid_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = ST_HOLD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                m_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            timer_q       <= '0;
            m_valid_q     <= 1'b0;
            m_resp_q      <= '0;
            m_rdata_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            timer_q       <= timer_d;
            m_valid_q     <= m_valid_d;
            m_resp_q      <= m_resp_d;
            m_rdata_q     <= m_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_resp      = m_resp_q;
    assign m_rdata     = m_rdata_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_resp_mux_n.sv
// tb_resp_mux_n: scoreboard bench for resp_mux_n with default parameters.
module tb_resp_mux_n;

    localparam int NS  = 3;
    localparam int SW  = 2;
    localparam int RW  = 2;
    localparam int DW  = 8;
    localparam int TO  = 15;
    localparam int EW  = RW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0;
    logic [SW-1:0]     req_sel = '0;
    logic [NS-1:0]     s_valid = '0;
    logic [NS*RW-1:0]  s_resp = '0;
    logic [NS*DW-1:0]  s_rdata = '0;
    logic [NS-1:0]     s_ready;
    logic              m_valid;
    logic [RW-1:0]     m_resp;
    logic [DW-1:0]     m_rdata;
    logic              m_ready = 1'b0;
    logic              busy;
    logic              timeout_err;

    resp_mux_n #(
        .NUM_SLAVES(NS), .SEL_W(SW), .RESP_W(RW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_sel(req_sel),
        .s_valid(s_valid), .s_resp(s_resp), .s_rdata(s_rdata), .s_ready(s_ready),
        .m_valid(m_valid), .m_resp(m_resp), .m_rdata(m_rdata), .m_ready(m_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int to_cnt = 0;

    always @(negedge clk) begin
        if (rstn && timeout_err) to_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [SW-1:0] sel);
        req_valid = 1'b1;
        req_sel   = sel;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drive_slave(input int i, input logic v, input logic [RW-1:0] r, input logic [DW-1:0] d);
        s_valid[i]         = v;
        s_resp[i*RW +: RW] = r;
        s_rdata[i*DW +: DW] = d;
    endtask

    // Random noise on all slaves except the one given.
    task automatic noise_others(input int keep);
        for (int i = 0; i < NS; i++) begin
            if (i != keep) drive_slave(i, 1'($urandom_range(0, 1)), RW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)));
        end
    endtask

    // Wait for m_valid, hold m_ready low for 'hold' cycles, then accept and
    // compare the delivered response against the head of the queue.
    task automatic accept(input string tag, input int hold);
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        for (int k = 0; k < TO + 8 && !m_valid; k++) tick();
        check({tag, "_valid"}, m_valid, 1'b1);
        got = {m_resp, m_rdata};
        for (int k = 0; k < hold; k++) begin
            tick();
            check({tag, "_hold"}, {m_valid, s_ready, busy, m_resp, m_rdata}, {1'b1, 3'b000, 1'b1, got});
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check({tag, "_drop"}, {m_valid, busy}, 2'b00);
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'(got), 32'hFFFF_FFFF);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_data"}, 32'(got), 32'(exp));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int to_before;
        int sel;
        int dly;
        logic [RW-1:0] r;
        logic [DW-1:0] d;

        // 1. reset hold with random inputs
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_sel   = SW'($urandom_range(0, 3));
            m_ready   = 1'($urandom_range(0, 1));
            noise_others(-1);
            tick();
            check("rst_outs", {s_ready, m_valid, m_resp, m_rdata, busy, timeout_err}, '0);
        end
        req_valid = 1'b0;
        m_ready   = 1'b0;
        s_valid   = '0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("rst_release_busy", busy, 1'b0);

        // 2. normal read from slave 1 with noise on slaves 0 and 2
        request(2'd1);
        check("rd_wait", {s_ready, busy}, {3'b010, 1'b1});
        exp_q.push_back({2'b00, 8'hA5});
        for (int k = 0; k < 2; k++) begin
            noise_others(1);
            tick();
            check("rd_ready", {s_ready, m_valid}, {3'b010, 1'b0});
        end
        drive_slave(1, 1'b1, 2'b00, 8'hA5);
        noise_others(1);
        tick();
        s_valid = '0;
        check("rd_latency", m_valid, 1'b1);
        accept("rd", 4);

        // 3. decode error
        request(2'd3);
        check("dec_resp", {m_valid, s_ready, m_resp, m_rdata}, {1'b1, 3'b000, 2'b11, 8'h00});
        exp_q.push_back({2'b11, 8'h00});
        accept("dec", 1);

        // 4a. timeout on silent slave 2
        to_before = to_cnt;
        request(2'd2);
        exp_q.push_back({2'b10, 8'h00});
        for (int k = 0; k < TO - 1; k++) tick();
        check("to_not_yet", m_valid, 1'b0);
        tick();
        check("to_pulse", {m_valid, timeout_err, m_resp}, {1'b1, 1'b1, 2'b10});
        accept("to", 2);
        check("to_count", to_cnt - to_before, 1);

        // 4b. slave response on the exact timeout cycle wins
        to_before = to_cnt;
        request(2'd2);
        exp_q.push_back({2'b01, 8'h3C});
        for (int k = 0; k < TO - 1; k++) tick();
        drive_slave(2, 1'b1, 2'b01, 8'h3C);
        tick();
        s_valid = '0;
        check("race_resp", {m_valid, timeout_err}, {1'b1, 1'b0});
        accept("race", 0);
        check("race_count", to_cnt - to_before, 0);

        // 5. requests during WAIT/HOLD are ignored
        request(2'd1);
        exp_q.push_back({2'b00, 8'h5A});
        req_valid = 1'b1;
        req_sel   = 2'd0;
        drive_slave(0, 1'b1, 2'b01, 8'h77);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("ign_wait", {s_ready, m_valid}, {3'b010, 1'b0});
        end
        drive_slave(1, 1'b1, 2'b00, 8'h5A);
        tick();
        s_valid = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("ign_hold", {m_valid, s_ready, m_rdata}, {1'b1, 3'b000, 8'h5A});
        end
        req_valid = 1'b0;
        accept("ign", 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("ign_idle", {busy, m_valid}, 2'b00);
        end

        // 6a. reset during WAIT with a pending slave response
        request(2'd0);
        drive_slave(0, 1'b1, 2'b00, 8'h11);
        rstn = 1'b0;
        #1;
        check("rst_wait", {m_valid, busy, s_ready}, '0);
        tick();
        s_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_wait_after", {m_valid, busy}, 2'b00);
        end

        // 6b. reset during HOLD
        request(2'd1);
        drive_slave(1, 1'b1, 2'b00, 8'h22);
        tick();
        s_valid = '0;
        check("rst_hold_pre", m_valid, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_hold", {m_valid, busy}, 2'b00);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_hold_after", {m_valid, busy}, 2'b00);
        end

        // random transactions
        for (int t = 0; t < 12; t++) begin
            sel = $urandom_range(0, 3);
            r   = RW'($urandom_range(0, 1));
            d   = DW'($urandom_range(0, 255));
            request(SW'(sel));
            if (sel >= NS) begin
                exp_q.push_back({2'b11, 8'h00});
            end else begin
                dly = $urandom_range(0, 5);
                for (int k = 0; k < dly; k++) begin
                    noise_others(sel);
                    tick();
                end
                noise_others(sel);
                drive_slave(sel, 1'b1, r, d);
                tick();
                s_valid = '0;
                exp_q.push_back({r, d});
            end
            accept("rnd", $urandom_range(0, 2));
        end

        check("queue_empty", exp_q.size(), 0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/resp_mux_n.md
Name: resp_mux_n

Overview:
Parametrised N-slave response return path for the system bus. It replaces the fixed 3:1 combinational response mux.
- Latches the target slave index at request time.
- Accepts the response only from that slave, under a valid/ready handshake.
- Registers response and read data toward the master and holds them until the master accepts.
- Unmapped indices and stalled slaves produce error responses instead of silently defaulting to slave 0.

Parameters:
NUM_SLAVES, 3, number of slave response channels (>=2)
SEL_W, 2, width of slave index; 2**SEL_W >= NUM_SLAVES
RESP_W, 2, response code width (>=2)
DATA_W, 8, read data width
TIMEOUT, 15, max cycles in WAIT before timeout error (>=2)

Ports:
clk  in  1  single system clock, rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request accepted on bus; latch req_sel (ignored when busy=1)
req_sel  in  SEL_W  target slave index
s_valid  in  NUM_SLAVES  per-slave response valid
s_resp  in  NUM_SLAVES*RESP_W  packed slave responses, slave i at [i*RESP_W +: RESP_W]
s_rdata  in  NUM_SLAVES*DATA_W  packed slave read data, slave i at [i*DATA_W +: DATA_W]
s_ready  out  NUM_SLAVES  per-slave response ready (one-hot or zero)
m_valid  out  1  response valid to master
m_resp  out  RESP_W  response code to master
m_rdata  out  DATA_W  read data to master
m_ready  in  1  master accepts response
busy  out  1  transaction in flight (state != IDLE)
timeout_err  out  1  one-cycle pulse when a timeout response is generated

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE, sel_q=0, timer=0.
  - m_valid=0, m_resp=0, m_rdata=0, s_ready=0, busy=0, timeout_err=0.
  - Asserting reset mid-transaction aborts it; no response is ever issued for the aborted request.
- Response codes:
  - OKAY is passed through from the slave.
  - TOERR = 2'b10 (zero-extended to RESP_W): slave timeout.
  - DECERR = 2'b11 (zero-extended): index >= NUM_SLAVES.
- State IDLE:
  - busy=0, s_ready=0, m_valid=0.
  - On req_valid: sel_q<=req_sel.
  - If req_sel >= NUM_SLAVES: m_resp<=DECERR, m_rdata<=0, m_valid<=1, goto HOLD.
  - Otherwise: timer<=0, goto WAIT.
- State WAIT:
  - busy=1.
  - s_ready[sel_q]=1 (combinational from state and sel_q); all other s_ready bits are 0.
  - s_valid and s_resp/s_rdata of non-selected slaves are ignored.
  - On s_valid[sel_q]: m_resp<=s_resp[sel_q], m_rdata<=s_rdata[sel_q], m_valid<=1, goto HOLD. Latency: slave handshake in cycle N gives m_valid=1 in cycle N+1.
  - Otherwise timer increments. When timer==TIMEOUT-1 and no s_valid[sel_q]: m_resp<=TOERR, m_rdata<=0, m_valid<=1, timeout_err<=1 for exactly one cycle, goto HOLD.
  - If s_valid[sel_q] and the timeout condition occur in the same cycle, s_valid wins: normal response, no timeout_err.
- State HOLD:
  - busy=1, s_ready=0, m_valid=1.
  - m_resp and m_rdata are stable until accepted.
  - On m_ready: m_valid<=0, goto IDLE.
  - m_ready=0 holds indefinitely; no timeout applies in HOLD.
- req_valid in WAIT or HOLD is ignored and not queued. A new request is only accepted in IDLE, which gives at least one idle cycle between transactions.
- Outputs m_resp and m_rdata retain their last values in IDLE; only m_valid qualifies them.
- Timer width: clog2(TIMEOUT)+1 bits; it never wraps.

Test Plan:
1. Reset hold: rstn=0 with random inputs -> all outputs 0. Release rstn mid-cycle -> state IDLE, busy=0.
2. Normal read: NUM_SLAVES=3, req_sel=1. Slave1 asserts s_valid 3 cycles later with resp=00, rdata=8'hA5; s_valid[0], s_valid[2] toggle meanwhile -> s_ready=3'b010 in WAIT; next cycle m_valid=1, m_resp=00, m_rdata=A5; held while m_ready=0 for 4 cycles; drops one cycle after m_ready=1.
3. Decode error: req_sel=3 -> next cycle m_valid=1, m_resp=11, m_rdata=0, s_ready never asserted.
4. Timeout: req_sel=2, slave 2 silent -> timeout_err single pulse, m_resp=10 after TIMEOUT cycles in WAIT. Variant: s_valid[2] on the exact timeout cycle -> slave response wins, no timeout_err.
5. Ignored request: req_valid with req_sel=0 during WAIT and HOLD of a slave-1 transaction -> sel_q unchanged, slave-1 response delivered, no second transaction started.
6. Reset mid-operation: rstn low during WAIT with s_valid pending, and again during HOLD -> m_valid=0 immediately, no response delivered after reset release.
